xif_result_arbiter: RTL and testbench
=====================================

Name: xif_result_arbiter

Overview:
- Merges N coprocessor XIF result channels (struct form, fpu_ss_pkg types) onto the single core-side result channel of the tile.
- Each coprocessor channel has a small input FIFO, so a coprocessor can write back without combinational dependence on core ready.
- A round-robin or fixed-priority arbiter then drives the core result port with valid/ready-stable semantics.
- Sits between the struct-side coprocessors (FPU subsystem, accelerators) and the interface-to-struct converter feeding cv32e40x.

Parameters:
- N_COPROC, 2, number of coprocessor result channels (>=1).
- FIFO_DEPTH, 2, entries per channel FIFO (>=1).
- ARB_MODE, xif_conv_pkg::ARB_RR, ARB_RR = round-robin, ARB_FIXED = lowest index wins.
- result_t, fpu_ss_pkg::x_result_t, result payload type.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- x_result_valid_i  in  N_COPROC  per-coprocessor result valid.
- x_result_ready_o  out  N_COPROC  per-coprocessor ready; equals !full of that FIFO.
- x_result_i  in  N_COPROC x $bits(result_t)  per-coprocessor result payload.
- x_result_valid_o  out  1  merged result valid to core.
- x_result_ready_i  in  1  core ready.
- x_result_o  out  $bits(result_t)  merged result payload.
- grant_idx_o  out  max(1,$clog2(N_COPROC))  index of the channel currently presented.
- busy_o  out  1  any FIFO non-empty.

Behaviour:
- Reset (async assert, sync release on clk_i): all FIFOs empty, rr pointer = 0, lock = 0. Outputs: x_result_ready_o = all 1, x_result_valid_o = 0, x_result_o = '0, grant_idx_o = 0, busy_o = 0.
- Push: channel i accepts on x_result_valid_i[i] && x_result_ready_o[i]. x_result_ready_o[i] is derived from registered occupancy only, with no path from x_result_ready_i.
- Full FIFO: ready_o = 0 even if a pop occurs the same cycle; the accept opportunity is lost for that cycle, which is intended.
- Simultaneous push and pop on a non-full FIFO: occupancy unchanged; data order preserved.
- Latency: a result accepted in cycle t is visible on x_result_o at earliest cycle t+1 (FIFO is not fall-through).
- Arbitration:
  - Request set = non-empty FIFOs.
  - ARB_RR: grant the first requester at or after rr pointer, modulo N_COPROC (wrap from N_COPROC-1 to 0).
  - ARB_FIXED: grant the lowest index.
- Lock:
  - Once x_result_valid_o = 1 with !x_result_ready_i, lock = 1 and grant, payload and valid hold until handshake, even if higher-priority requests appear.
  - Lock clears on handshake.
- Handshake (valid_o && ready_i): pop the granted FIFO. In ARB_RR, rr pointer = granted+1 (wrap).
- Back-to-back: one result per cycle while ready_i = 1. Consecutive grants rotate across requesters in RR mode.
- No requesters: valid_o = 0, x_result_o = '0, grant_idx_o holds its last value.
- x_result_o = head entry of the granted FIFO (combinational mux from registered storage).
- N_COPROC = 1: arbiter degenerates to a pass-through of the FIFO; grant_idx_o tied to 0.
- FIFO_DEPTH = 1: channel alternates accept/present; maximum throughput per channel is 1 result per 2 cycles.
- Reset mid-operation: all pending results are dropped. No ordering guarantee across channels; per-channel order is strict FIFO.
- Assertions (sim only):
  - x_result_o stable while valid_o && !ready_i.
  - No push into a full FIFO.
  - No pop from an empty FIFO.

Decomposition:
- xif_conv_pkg holds:
  - typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e.
  - Helper localparam function for grant index width.
- result_t comes from fpu_ss_pkg; no new payload types.
- Sub-module xif_result_fifo (parametrised by DEPTH and type), instantiated N_COPROC times. It provides:
  - registered storage;
  - wrap-around read/write pointers;
  - count, full and empty flags;
  - the same async active-high reset.
- Arbitration and lock logic stay in the top module.

Test Plan:
- Reset release: after rst_i deasserts, ready_o = 2'b11, valid_o = 0, busy_o = 0. Push id=3 on ch0 at cycle t -> x_result_o.id = 3, valid_o = 1 at t+1, grant_idx_o = 0.
- RR fairness: N=2, both channels push 4 results each, ready_i = 1 -> output order ch0,ch1,ch0,ch1,... with ids interleaved and 8 handshakes in 8 cycles.
- Backpressure lock: ch1 presented with ready_i = 0 for 5 cycles while ch0 becomes non-empty -> grant_idx_o stays 1 and payload stable; after ready_i = 1, ch0 is presented the next cycle.
- Full FIFO: DEPTH=2, ready_i = 0, ch0 pushes 3 times -> ready_o[0] drops after the second accept and the third is held. Raise ready_i -> third accepted one cycle after the first pop.
- ARB_FIXED: both channels continuously pushing -> ch0 always wins while non-empty; ch1 is served only when ch0 is empty.
- Reset mid-op: both FIFOs hold 2 entries, assert rst_i asynchronously -> valid_o = 0 and busy_o = 0 immediately; no stale result emerges after release.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// Result payload type shared by the FPU subsystem and the coprocessor tile.
package fpu_ss_pkg;

  localparam int X_ID_WIDTH = 4;
  localparam int X_RFW_WIDTH = 32;

  // Coprocessor result payload as seen on the struct side of the XIF
  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic [1:0]             we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

endpackage

// File: rtl/xif_conv_pkg.sv
// Shared arbitration types and sizing helpers for the XIF conversion blocks.
package xif_conv_pkg;

  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;

  // Width of an index into n channels; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xif_result_fifo.sv
// Small synchronous FIFO holding coprocessor results; head entry is read
// combinationally from registered storage (no fall-through).
module xif_result_fifo #(
  parameter int  DEPTH  = 2,
  parameter type data_t = logic
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  data_t                        wdata,
  output data_t                        rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  data_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is written only; it carries no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full))
    else $error("xif_result_fifo: push into full fifo");
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(pop && empty))
    else $error("xif_result_fifo: pop from empty fifo");

endmodule

// File: rtl/xif_result_arbiter.sv
// Merges N coprocessor result channels onto the single core result port.
// Each channel is buffered in its own FIFO; a round-robin or fixed-priority
// arbiter picks a non-empty FIFO and locks onto it while the core stalls.
module xif_result_arbiter
  import xif_conv_pkg::*;
#(
  parameter int        N_COPROC   = 2,
  parameter int        FIFO_DEPTH = 2,
  parameter arb_mode_e ARB_MODE   = ARB_RR,
  parameter type       result_t   = fpu_ss_pkg::x_result_t
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic    [N_COPROC-1:0]            x_result_valid_i,
  output logic    [N_COPROC-1:0]            x_result_ready_o,
  input  result_t [N_COPROC-1:0]            x_result_i,
  output logic                              x_result_valid_o,
  input  logic                              x_result_ready_i,
  output result_t                           x_result_o,
  output logic    [idx_width(N_COPROC)-1:0] grant_idx_o,
  output logic                              busy_o
);

  localparam int GW = idx_width(N_COPROC);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [N_COPROC-1:0] push;
  logic [N_COPROC-1:0] pop;
  logic [N_COPROC-1:0] full;
  logic [N_COPROC-1:0] empty;
  logic [N_COPROC-1:0] req;
  logic [N_COPROC-1:0] occupied;
  result_t             head  [N_COPROC];
  logic [CW-1:0]       count [N_COPROC];

  logic [GW-1:0] cand;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr_reg;
  logic [GW-1:0] lock_idx_reg;
  logic [GW-1:0] last_grant_reg;
  logic          lock_reg;
  logic          handshake;

  genvar gi;
  generate
    for (gi = 0; gi < N_COPROC; gi++) begin : g_chan
      // Ready depends on registered occupancy only, never on core ready
      assign x_result_ready_o[gi] = !full[gi];
      assign push[gi]             = x_result_valid_i[gi] && !full[gi];
      assign pop[gi]              = handshake && (grant == GW'(gi));
      assign req[gi]              = !empty[gi];
      assign occupied[gi]         = (count[gi] != '0);

      xif_result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .data_t (result_t)
      ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .wdata (x_result_i[gi]),
        .rdata (head[gi]),
        .count (count[gi]),
        .full  (full[gi]),
        .empty (empty[gi])
      );
    end
  endgenerate

  // Pick the next requester: first at/after rr pointer, or lowest index
  always_comb begin
    int   idx;
    logic found;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_COPROC; k++) begin
      if (ARB_MODE == ARB_RR) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= N_COPROC) idx = idx - N_COPROC;
      end else begin
        idx = k;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        cand  = idx[GW-1:0];
      end
    end
  end

  // While the core stalls, the presented channel is frozen by the lock
  assign grant            = lock_reg ? lock_idx_reg : cand;
  assign x_result_valid_o = |req;
  assign handshake        = x_result_valid_o && x_result_ready_i;
  assign x_result_o       = x_result_valid_o ? head[grant] : '0;
  assign grant_idx_o      = x_result_valid_o ? grant : last_grant_reg;
  assign busy_o           = |occupied;

  // Arbiter state: rr pointer advances past the winner, lock holds a stalled grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_reg     <= '0;
      lock_reg       <= 1'b0;
      lock_idx_reg   <= '0;
      last_grant_reg <= '0;
    end else begin
      if (x_result_valid_o) last_grant_reg <= grant;
      if (handshake) begin
        lock_reg <= 1'b0;
        if (ARB_MODE == ARB_RR)
          rr_ptr_reg <= (grant == GW'(N_COPROC - 1)) ? '0 : grant + 1'b1;
      end else if (x_result_valid_o) begin
        lock_reg     <= 1'b1;
        lock_idx_reg <= grant;
      end
    end
  end

  a_stable_stall : assert property (@(posedge clk_i) disable iff (rst_i)
    (x_result_valid_o && !x_result_ready_i) |=>
      (x_result_valid_o && $stable(x_result_o) && $stable(grant_idx_o)))
    else $error("xif_result_arbiter: output changed during stall");

endmodule

// File: tb/tb_xif_result_arbiter.sv
// Directed bench for xif_result_arbiter: one round-robin and one
// fixed-priority instance, each with two channels of depth two.
module tb_xif_result_arbiter;
  import fpu_ss_pkg::*;
  import xif_conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      valid_in, ready_out;
  x_result_t [1:0] data_in;
  logic            valid_out, ready_in, busy;
  x_result_t       data_out;
  logic [0:0]      grant;

  logic [1:0]      f_valid_in, f_ready_out;
  x_result_t [1:0] f_data_in;
  logic            f_valid_out, f_ready_in, f_busy;
  x_result_t       f_data_out;
  logic [0:0]      f_grant;

  int n_checks = 0;
  int n_errors = 0;

  xif_result_arbiter #(.N_COPROC(2), .FIFO_DEPTH(2), .ARB_MODE(ARB_RR)) dut (
    .clk_i(clk), .rst_i(rst),
    .x_result_valid_i(valid_in), .x_result_ready_o(ready_out), .x_result_i(data_in),
    .x_result_valid_o(valid_out), .x_result_ready_i(ready_in), .x_result_o(data_out),
    .grant_idx_o(grant), .busy_o(busy)
  );

  xif_result_arbiter #(.N_COPROC(2), .FIFO_DEPTH(2), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk_i(clk), .rst_i(rst),
    .x_result_valid_i(f_valid_in), .x_result_ready_o(f_ready_out), .x_result_i(f_data_in),
    .x_result_valid_o(f_valid_out), .x_result_ready_i(f_ready_in), .x_result_o(f_data_out),
    .grant_idx_o(f_grant), .busy_o(f_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic x_result_t mk(input logic [3:0] id);
    x_result_t r;
    r      = '0;
    r.id   = id;
    r.data = {28'hC0FFEE0, id};
    r.rd   = 5'(id) + 5'd1;
    r.we   = 2'b01;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i0, i1, exp_id;
    logic acc0, acc1;
    logic [3:0] fx_seq [8];
    fx_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};

    valid_in = '0; data_in = '0; ready_in = 1'b0;
    f_valid_in = '0; f_data_in = '0; f_ready_in = 1'b0;

    // reset and release
    repeat (3) tick;
    #1;
    check("in_reset_valid", valid_out, 0);
    check("in_reset_busy", busy, 0);
    rst = 1'b0;
    #1;
    $display("step reset_release");
    check("rst_ready", ready_out, 2'b11);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_data", 64'(data_out), 0);

    // single push on ch0: visible one cycle later
    tick;
    valid_in = 2'b01; data_in[0] = mk(4'd3);
    #1;
    check("t1_no_fallthrough", valid_out, 0);
    tick;
    valid_in = '0;
    #1;
    $display("step single_push");
    check("t1_valid", valid_out, 1);
    check("t1_data", 64'(data_out), 64'(mk(4'd3)));
    check("t1_grant", grant, 0);
    check("t1_busy", busy, 1);
    ready_in = 1'b1;
    tick;
    #1;
    check("t1_drained", {busy, valid_out}, 0);
    ready_in = 1'b0;

    // reset pulse so the rr pointer starts from channel 0
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick;

    // round-robin fairness, both channels streaming, core always ready
    i0 = 0; i1 = 0; exp_id = 0;
    ready_in = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      valid_in[0] = (i0 < 4); data_in[0] = mk(4'(2 * i0));
      valid_in[1] = (i1 < 4); data_in[1] = mk(4'(2 * i1 + 1));
      #1;
      if (cyc >= 1 && cyc <= 8) begin
        $display("rr cycle %0d id %0d grant %0d", cyc, data_out.id, grant);
        check("rr_valid", valid_out, 1);
        check("rr_id", data_out.id, exp_id);
        check("rr_grant", grant, exp_id % 2);
        exp_id++;
      end else if (cyc == 9) begin
        check("rr_drained", {busy, valid_out}, 0);
        check("rr_grant_hold", grant, 1);
      end
      acc0 = valid_in[0] && ready_out[0];
      acc1 = valid_in[1] && ready_out[1];
      tick;
      if (acc0) i0++;
      if (acc1) i1++;
    end
    valid_in = '0;
    ready_in = 1'b0;

    // backpressure lock: ch1 presented, ch0 arrives during the stall
    valid_in = 2'b10; data_in[1] = mk(4'd9);
    tick;
    valid_in = '0;
    #1;
    check("lock_first_grant", grant, 1);
    check("lock_first_data", 64'(data_out), 64'(mk(4'd9)));
    valid_in = 2'b01; data_in[0] = mk(4'd8);
    tick;
    valid_in = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      $display("lock cycle %0d grant %0d id %0d", k, grant, data_out.id);
      check("lock_grant", grant, 1);
      check("lock_data", 64'(data_out), 64'(mk(4'd9)));
      tick;
    end
    ready_in = 1'b1;
    #1;
    check("lock_release_grant", grant, 1);
    tick;
    #1;
    check("lock_next_grant", grant, 0);
    check("lock_next_data", 64'(data_out), 64'(mk(4'd8)));
    tick;
    #1;
    check("lock_drained", {busy, valid_out}, 0);
    ready_in = 1'b0;

    // full fifo on ch0 with core stalled
    valid_in = 2'b01; data_in[0] = mk(4'd1);
    #1;
    check("full_ready_a", ready_out[0], 1);
    tick;
    data_in[0] = mk(4'd2);
    #1;
    check("full_ready_b", ready_out[0], 1);
    tick;
    data_in[0] = mk(4'd3);
    #1;
    $display("step full_fifo");
    check("full_ready_c", ready_out[0], 0);
    tick;
    #1;
    check("full_ready_hold", ready_out[0], 0);
    ready_in = 1'b1;
    #1;
    check("full_ready_pop_cycle", ready_out[0], 0);
    check("full_head1", 64'(data_out), 64'(mk(4'd1)));
    tick;
    #1;
    check("full_ready_after_pop", ready_out[0], 1);
    check("full_head2", 64'(data_out), 64'(mk(4'd2)));
    tick;
    valid_in = '0;
    #1;
    check("full_head3", 64'(data_out), 64'(mk(4'd3)));
    check("full_valid3", valid_out, 1);
    tick;
    #1;
    check("full_drained", {busy, valid_out}, 0);
    ready_in = 1'b0;

    // reset in the middle of operation with both fifos full
    valid_in = 2'b11; data_in[0] = mk(4'd4); data_in[1] = mk(4'd5);
    tick;
    data_in[0] = mk(4'd6); data_in[1] = mk(4'd7);
    tick;
    valid_in = '0;
    #1;
    check("mid_busy", busy, 1);
    check("mid_ready", ready_out, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    $display("step async_reset");
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", 64'(data_out), 0);
    check("mid_rst_ready", ready_out, 2'b11);
    tick;
    tick;
    rst = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mid_no_stale", {busy, valid_out}, 0);
      tick;
    end
    ready_in = 1'b0;

    // fixed priority: ch0 wins while it has data, ch1 only afterwards
    i0 = 0; i1 = 0;
    f_ready_in = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      f_valid_in[0] = (i0 < 4); f_data_in[0] = mk(4'(i0));
      f_valid_in[1] = (i1 < 4); f_data_in[1] = mk(4'(8 + i1));
      #1;
      if (cyc >= 1 && cyc <= 8) begin
        $display("fx cycle %0d id %0d grant %0d", cyc, f_data_out.id, f_grant);
        check("fx_valid", f_valid_out, 1);
        check("fx_id", f_data_out.id, fx_seq[cyc-1]);
        check("fx_grant", f_grant, (cyc >= 5) ? 1 : 0);
      end else if (cyc == 9) begin
        check("fx_drained", {f_busy, f_valid_out}, 0);
      end
      acc0 = f_valid_in[0] && f_ready_out[0];
      acc1 = f_valid_in[1] && f_ready_out[1];
      tick;
      if (acc0) i0++;
      if (acc1) i1++;
    end
    f_valid_in = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
